// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipeline_ctrl_pkg;

  localparam int unsigned EN_W  = 5;
  localparam int unsigned CLR_W = 4;

  // Load-enable bit positions.
  localparam int unsigned EN_PC    = 0;
  localparam int unsigned EN_IFID  = 1;
  localparam int unsigned EN_IDEX  = 2;
  localparam int unsigned EN_EXMEM = 3;
  localparam int unsigned EN_MEMWB = 4;

  // Synchronous-clear bit positions.
  localparam int unsigned CLR_IFID  = 0;
  localparam int unsigned CLR_IDEX  = 1;
  localparam int unsigned CLR_EXMEM = 2;
  localparam int unsigned CLR_MEMWB = 3;

  // Enable/clear patterns for each pipeline action.
  localparam logic [EN_W-1:0]  EN_NONE      = 5'b00000;
  localparam logic [EN_W-1:0]  EN_ALL       = 5'b11111;
  localparam logic [EN_W-1:0]  EN_LOAD_USE  = 5'b11100;
  localparam logic [EN_W-1:0]  EN_PC_FROZEN = 5'b11110;
  localparam logic [CLR_W-1:0] CLR_NONE     = 4'b0000;
  localparam logic [CLR_W-1:0] CLR_ALL      = 4'b1111;
  localparam logic [CLR_W-1:0] CLR_BRANCH   = 4'b0011;
  localparam logic [CLR_W-1:0] CLR_LOAD_USE = 4'b0010;
  localparam logic [CLR_W-1:0] CLR_DRAIN    = 4'b0001;

  typedef enum logic [2:0] {
    ST_FLUSH    = 3'd0,
    ST_RUN      = 3'd1,
    ST_MEM_WAIT = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_HALTED   = 3'd4
  } state_e;

  // Per-cycle control word presented to the pipeline registers.
  typedef struct packed {
    logic [EN_W-1:0]  en;
    logic [CLR_W-1:0] clr;
  } ctrl_t;

  function automatic ctrl_t mk_ctrl(input logic [EN_W-1:0] en, input logic [CLR_W-1:0] clr);
    ctrl_t c;
    c.en  = en;
    c.clr = clr;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and register-control outputs of the pipeline controller.
interface pipeline_ctrl_if #(parameter int unsigned CNT_W = 16);
  import pipeline_ctrl_pkg::*;

  logic             load_use;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             halt_req;
  logic [EN_W-1:0]  en;
  logic [CLR_W-1:0] clr;
  logic             halted;
  logic             mem_err;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output load_use, branch_taken, mem_req, mem_ready, halt_req,
    input  en, clr, halted, mem_err, stall_count
  );

  modport slave (
    input  load_use, branch_taken, mem_req, mem_ready, halt_req,
    output en, clr, halted, mem_err, stall_count
  );
endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);

  // Count register: holds at all-ones once reached.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Sequencing controller for the pipeline registers of the 5-stage core:
// reset flush, load-use bubbles, branch flushes, memory-wait freezes,
// halt/drain, plus a saturating stall-cycle counter for debug.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned NUM_STAGES  = 4,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic            clk,
  input  logic            rst,
  pipeline_ctrl_if.slave  bus
);

  localparam int unsigned PH_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int unsigned WT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(NUM_STAGES - 1);
  localparam logic [WT_W-1:0] WT_MAX  = WT_W'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [WT_W-1:0]  wait_q;
  logic [CNT_W-1:0] stall_q;
  logic             mem_err_q, halted_q;
  logic             mem_busy;
  logic             wait_inc, wait_clr, err_set, stall_inc;
  ctrl_t            ctrl;

  assign mem_busy = bus.mem_req & ~bus.mem_ready;

  // State, phase and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_FLUSH;
      phase_q   <= '0;
      mem_err_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      halted_q <= (state_d == ST_HALTED);
      if (err_set) begin
        mem_err_q <= 1'b1;
      end
    end
  end

  // Next-state and Mealy enable/clear decode.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    ctrl     = mk_ctrl(EN_NONE, CLR_NONE);
    wait_inc = 1'b0;
    wait_clr = 1'b0;
    err_set  = 1'b0;
    case (state_q)
      ST_FLUSH: begin
        ctrl = mk_ctrl(EN_ALL, CLR_ALL);
        if (phase_q == PH_LAST) begin
          state_d = ST_RUN;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      ST_RUN, ST_MEM_WAIT: begin
        if (mem_busy) begin
          if (state_q == ST_RUN) begin
            state_d  = ST_MEM_WAIT;
            wait_inc = 1'b1;
          end else if (wait_q == WT_MAX) begin
            state_d = ST_HALTED;
            err_set = 1'b1;
          end else begin
            wait_inc = 1'b1;
          end
        end else begin
          wait_clr = 1'b1;
          state_d  = ST_RUN;
          if (bus.branch_taken) begin
            ctrl = mk_ctrl(EN_ALL, CLR_BRANCH);
          end else if (bus.load_use) begin
            ctrl = mk_ctrl(EN_LOAD_USE, CLR_LOAD_USE);
          end else if (bus.halt_req) begin
            ctrl    = mk_ctrl(EN_PC_FROZEN, CLR_DRAIN);
            state_d = ST_DRAIN;
            phase_d = '0;
          end else begin
            ctrl = mk_ctrl(EN_ALL, CLR_NONE);
          end
        end
      end
      ST_DRAIN: begin
        // A pending memory access freezes the drain without consuming a phase.
        if (!mem_busy) begin
          ctrl = mk_ctrl(EN_PC_FROZEN, CLR_DRAIN);
          if (phase_q == PH_LAST) begin
            state_d = ST_HALTED;
            phase_d = '0;
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_FLUSH;
        phase_d = '0;
      end
    endcase
  end

  // Stall accounting: PC held while the pipeline is live.
  assign stall_inc = ((state_q == ST_RUN) || (state_q == ST_MEM_WAIT)) & ~ctrl.en[EN_PC];

  sat_counter #(.WIDTH(WT_W)) u_wait_cnt (
    .clk (clk),
    .rst (rst),
    .inc (wait_inc),
    .clr (wait_clr),
    .q   (wait_q)
  );

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .clr (1'b0),
    .q   (stall_q)
  );

  assign bus.en          = ctrl.en;
  assign bus.clr         = ctrl.clr;
  assign bus.halted      = halted_q;
  assign bus.mem_err     = mem_err_q;
  assign bus.stall_count = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: two instances (4-bit and 16-bit stall
// counters) share stimulus; a behavioural model queues expected outputs.
module tb_pipeline_ctrl;

  localparam int N_ST = 4;
  localparam int TMO  = 16;

  localparam int M_FLUSH = 0;
  localparam int M_RUN   = 1;
  localparam int M_WAIT  = 2;
  localparam int M_DRAIN = 3;
  localparam int M_HALT  = 4;

  typedef struct {
    logic [4:0]  en;
    logic [3:0]  clr;
    logic        halted;
    logic        mem_err;
    logic [3:0]  s4;
    logic [15:0] s16;
  } exp_t;

  logic clk;
  logic rst;
  logic load_use, branch_taken, mem_req, mem_ready, halt_req;

  pipeline_ctrl_if #(.CNT_W(4))  bus4 ();
  pipeline_ctrl_if #(.CNT_W(16)) bus16 ();

  assign bus4.load_use      = load_use;
  assign bus4.branch_taken  = branch_taken;
  assign bus4.mem_req       = mem_req;
  assign bus4.mem_ready     = mem_ready;
  assign bus4.halt_req      = halt_req;
  assign bus16.load_use     = load_use;
  assign bus16.branch_taken = branch_taken;
  assign bus16.mem_req      = mem_req;
  assign bus16.mem_ready    = mem_ready;
  assign bus16.halt_req     = halt_req;

  pipeline_ctrl #(.NUM_STAGES(N_ST), .MEM_TIMEOUT(TMO), .CNT_W(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  pipeline_ctrl #(.NUM_STAGES(N_ST), .MEM_TIMEOUT(TMO), .CNT_W(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state.
  int m_mode  = M_FLUSH;
  int m_cnt   = 0;
  int m_wcnt  = 0;
  int m_stall = 0;
  bit m_err   = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
    end
  endtask

  // Apply one cycle of inputs, predict that cycle's outputs, advance the model.
  task automatic drive(input bit r, input bit lu, input bit br, input bit mr,
                       input bit rdy, input bit hr);
    exp_t e;
    bit   busy;
    int   n_mode, n_cnt, n_wcnt;
    bit   n_err;
    logic [4:0] en_e;
    logic [3:0] clr_e;
    @(posedge clk);
    #1;
    rst = r; load_use = lu; branch_taken = br; mem_req = mr; mem_ready = rdy; halt_req = hr;
    if (!r) begin
      m_mode = M_FLUSH; m_cnt = 0; m_wcnt = 0; m_stall = 0; m_err = 1'b0;
    end
    e.halted  = (m_mode == M_HALT);
    e.mem_err = m_err;
    e.s4      = 4'((m_stall > 15) ? 15 : m_stall);
    e.s16     = 16'((m_stall > 65535) ? 65535 : m_stall);
    busy   = mr && !rdy;
    en_e   = 5'b00000;
    clr_e  = 4'b0000;
    n_mode = m_mode; n_cnt = m_cnt; n_wcnt = m_wcnt; n_err = m_err;
    case (m_mode)
      M_FLUSH: begin
        en_e = 5'b11111; clr_e = 4'b1111;
        n_cnt = m_cnt + 1;
        if (n_cnt == N_ST) begin n_mode = M_RUN; n_cnt = 0; end
      end
      M_RUN, M_WAIT: begin
        if (busy) begin
          if (m_mode == M_RUN) begin n_mode = M_WAIT; n_wcnt = 1; end
          else if (m_wcnt == TMO) begin n_mode = M_HALT; n_err = 1'b1; end
          else n_wcnt = m_wcnt + 1;
        end else begin
          n_wcnt = 0;
          n_mode = M_RUN;
          if (br)      begin en_e = 5'b11111; clr_e = 4'b0011; end
          else if (lu) begin en_e = 5'b11100; clr_e = 4'b0010; end
          else if (hr) begin en_e = 5'b11110; clr_e = 4'b0001; n_mode = M_DRAIN; n_cnt = 0; end
          else         begin en_e = 5'b11111; clr_e = 4'b0000; end
        end
      end
      M_DRAIN: begin
        if (!busy) begin
          en_e = 5'b11110; clr_e = 4'b0001;
          n_cnt = m_cnt + 1;
          if (n_cnt == N_ST) begin n_mode = M_HALT; n_cnt = 0; end
        end
      end
      default: ;
    endcase
    e.en  = en_e;
    e.clr = clr_e;
    expq.push_back(e);
    if (r) begin
      if ((m_mode == M_RUN || m_mode == M_WAIT) && !en_e[0]) m_stall++;
      m_mode = n_mode; m_cnt = n_cnt; m_wcnt = n_wcnt; m_err = n_err;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compare DUT outputs against the queued prediction each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("en",          32'(bus4.en),           32'(e.en));
        chk("clr",         32'(bus4.clr),          32'(e.clr));
        chk("halted",      32'(bus4.halted),       32'(e.halted));
        chk("mem_err",     32'(bus4.mem_err),      32'(e.mem_err));
        chk("stall4",      32'(bus4.stall_count),  32'(e.s4));
        chk("stall16",     32'(bus16.stall_count), 32'(e.s16));
        chk("en16",        32'(bus16.en),          32'(e.en));
        chk("halted16",    32'(bus16.halted),      32'(e.halted));
      end
    end
  end

  // Watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus: directed scenarios then randomized traffic.
  initial begin
    int halt_run;
    rst = 1'b0; load_use = 0; branch_taken = 0; mem_req = 0; mem_ready = 0; halt_req = 0;
    // Reset, flush, run
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 1, 1, 1, 0, 1);
    idle(7);
    // Load-use bubble, then branch overriding load-use
    drive(1, 1, 0, 0, 0, 0);
    idle(2);
    drive(1, 1, 1, 0, 0, 0);
    idle(1);
    // Memory wait 3 cycles released by ready, with same-cycle req/ready
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 1, 1, 0);
    drive(1, 1, 0, 1, 1, 0);
    idle(1);
    // Release from wait straight into halt
    drive(1, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 1, 1, 1);
    drive(1, 0, 0, 1, 0, 0);
    idle(6);
    // Reset, then memory timeout
    drive(0, 0, 0, 0, 0, 0);
    idle(5);
    for (int i = 0; i < TMO + 3; i++) drive(1, 0, 1, 1, 0, 1);
    idle(3);
    // Reset, halt pulse, drain with a memory freeze inside
    drive(0, 0, 0, 0, 0, 0);
    idle(5);
    drive(1, 0, 0, 0, 0, 1);
    drive(1, 1, 1, 0, 0, 1);
    drive(1, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 1, 0, 0);
    idle(6);
    // Reset mid-drain and mid-wait
    drive(0, 0, 0, 0, 0, 0);
    idle(5);
    drive(1, 0, 0, 0, 0, 1);
    idle(1);
    drive(0, 0, 0, 0, 0, 0);
    idle(5);
    for (int i = 0; i < 6; i++) drive(1, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    idle(5);
    // Stall saturation: load_use held 20 cycles
    for (int i = 0; i < 20; i++) drive(1, 1, 0, 0, 0, 0);
    idle(2);
    // Randomized traffic with occasional resets and restarts after halt
    halt_run = 0;
    for (int i = 0; i < 1500; i++) begin
      bit r;
      r = ($urandom_range(199) != 0);
      if (m_mode == M_HALT) begin
        halt_run++;
        if (halt_run > 3) begin r = 1'b0; halt_run = 0; end
      end
      drive(r, ($urandom_range(3) == 0), ($urandom_range(5) == 0),
            ($urandom_range(1) == 0), ($urandom_range(2) != 0),
            ($urandom_range(49) == 0));
    end
    // Long busy burst under random traffic for timeout coverage
    for (int i = 0; i < TMO + 2; i++) drive(1, ($urandom_range(1) == 0), 0, 1, 0, 0);
    idle(2);
    @(negedge clk);
    #1;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain_queue: %0d entries left, expected 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
